// File: rtl/axi_integrate_dump.sv
// Integrate-and-dump decimator for a tready-less AXI-Stream sample path.
// Sums 2^LOG2_N valid signed samples and emits one rounded mean per window.
// An I_sync beat restarts the window and becomes beat 0 of the new window.
module axi_integrate_dump #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned LOG2_N = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] I_tdata,
    input  logic             I_tvalid,
    input  logic             I_sync,
    output logic [WIDTH-1:0] O_tdata,
    output logic             O_tvalid
);

    localparam int unsigned N     = 1 << LOG2_N;
    localparam int unsigned ACC_W = WIDTH + LOG2_N;

    localparam logic [LOG2_N-1:0]       CNT_LAST = LOG2_N'(N - 1);
    localparam logic signed [ACC_W-1:0] HALF     = ACC_W'(N / 2);

    logic signed [ACC_W-1:0] acc;
    logic [LOG2_N-1:0]       cnt;

    logic signed [ACC_W-1:0] din_c;
    logic signed [ACC_W-1:0] sum_c;
    logic signed [ACC_W-1:0] rnd_c;
    logic signed [ACC_W-1:0] mean_c;
    logic                    last_c;

    // Window sum, round-half-up bias and arithmetic divide by N
    always_comb begin
        din_c  = {{LOG2_N{I_tdata[WIDTH-1]}}, I_tdata};
        sum_c  = acc + din_c;
        rnd_c  = sum_c + HALF;
        mean_c = rnd_c >>> LOG2_N;
        // A sync beat always wins over the would-be closing beat
        last_c = I_tvalid && !I_sync && (cnt == CNT_LAST);
    end

    // Accumulator and beat counter; both hold while I_tvalid is low
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (I_tvalid) begin
            if (I_sync || (cnt == '0)) begin
                acc <= din_c;
                cnt <= LOG2_N'(1);
            end else if (cnt == CNT_LAST) begin
                cnt <= '0;
            end else begin
                acc <= sum_c;
                cnt <= cnt + LOG2_N'(1);
            end
        end
    end

    // One-cycle output pulse per completed window; data holds between pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            O_tdata  <= '0;
            O_tvalid <= 1'b0;
        end else begin
            O_tvalid <= last_c;
            if (last_c) begin
                O_tdata <= WIDTH'(mean_c);
            end
        end
    end

endmodule

// File: tb/tb_axi_integrate_dump.sv
// Bench for axi_integrate_dump (WIDTH=16, LOG2_N=3): directed scenarios plus a
// randomized run, all checked against a window-queue reference model.
module tb_axi_integrate_dump;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned LOG2_N = 3;
    localparam int          N      = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] I_tdata;
    logic             I_tvalid;
    logic             I_sync;
    logic [WIDTH-1:0] O_tdata;
    logic             O_tvalid;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: samples of the open window, predicted outputs
    int               win_q[$];
    logic             m_valid;
    logic [WIDTH-1:0] m_data;

    always #5 clk = ~clk;

    axi_integrate_dump #(
        .WIDTH (WIDTH),
        .LOG2_N(LOG2_N)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .I_tdata (I_tdata),
        .I_tvalid(I_tvalid),
        .I_sync  (I_sync),
        .O_tdata (O_tdata),
        .O_tvalid(O_tvalid)
    );

    // Drive one clock of input, then advance the model to what the outputs must show
    task automatic step(input int d, input logic v, input logic s);
        longint sum;
        longint q;
        I_tdata  = WIDTH'(d);
        I_tvalid = v;
        I_sync   = s;
        @(posedge clk);
        #1;
        m_valid = 1'b0;
        if (v) begin
            if (s) win_q.delete();
            win_q.push_back(d);
            if (win_q.size() == N) begin
                sum = 0;
                foreach (win_q[i]) sum += longint'(win_q[i]);
                q = sum + N / 2;
                // floor((sum + N/2) / N)
                if (q >= 0) q = q / N;
                else        q = -((-q + N - 1) / N);
                m_valid = 1'b1;
                m_data  = WIDTH'(q);
                win_q.delete();
            end
        end
    endtask

    // Hold reset low for the given clocks; leaves rst_n low for the caller
    task automatic do_reset(input int cycles);
        rst_n    = 1'b0;
        I_tvalid = 1'b0;
        I_sync   = 1'b0;
        I_tdata  = '0;
        repeat (cycles) @(posedge clk);
        #1;
        win_q.delete();
        m_valid = 1'b0;
        m_data  = '0;
    endtask

    function automatic int rand_sample();
        logic signed [WIDTH-1:0] r;
        r = WIDTH'($urandom);
        return int'(r);
    endfunction

    task automatic test_reset();
        do_reset(2);
        tests_run++;
        if (O_tvalid !== 1'b0 || O_tdata !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset: O_tvalid=%0b O_tdata=%0d, want 0/0", O_tvalid, O_tdata);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_constant();
        for (int i = 1; i <= N; i++) begin
            step(100, 1'b1, 1'b0);
            tests_run++;
            if (O_tvalid !== (i == N) || O_tdata !== m_data) begin
                tests_failed++;
                $display("FAIL constant beat %0d: O_tvalid=%0b O_tdata=%0d, want %0b/%0d",
                         i, O_tvalid, O_tdata, (i == N), m_data);
            end
        end
        tests_run++;
        if (O_tdata !== 16'd100) begin
            tests_failed++;
            $display("FAIL constant value: O_tdata=%0d, want 100", O_tdata);
        end
        step(0, 1'b0, 1'b0);
        tests_run++;
        if (O_tvalid !== 1'b0 || O_tdata !== 16'd100) begin
            tests_failed++;
            $display("FAIL constant hold: O_tvalid=%0b O_tdata=%0d, want 0/100", O_tvalid, O_tdata);
        end
    endtask

    task automatic test_ramp_gaps();
        int pulses = 0;
        for (int i = 1; i <= N; i++) begin
            for (int g = 0; g < 2; g++) begin
                step($urandom_range(0, 999), 1'b0, ($urandom_range(0, 1) == 1));
                tests_run++;
                if (O_tvalid !== 1'b0 || O_tdata !== m_data) begin
                    tests_failed++;
                    $display("FAIL ramp gap %0d: O_tvalid=%0b O_tdata=%0d, want 0/%0d",
                             i, O_tvalid, O_tdata, m_data);
                end
            end
            step(i, 1'b1, 1'b0);
            if (O_tvalid === 1'b1) pulses++;
            tests_run++;
            if (O_tvalid !== (i == N) || O_tdata !== m_data) begin
                tests_failed++;
                $display("FAIL ramp beat %0d: O_tvalid=%0b O_tdata=%0d, want %0b/%0d",
                         i, O_tvalid, O_tdata, (i == N), m_data);
            end
        end
        tests_run++;
        if (pulses != 1 || O_tdata !== 16'd5) begin
            tests_failed++;
            $display("FAIL ramp result: pulses=%0d O_tdata=%0d, want 1/5", pulses, O_tdata);
        end
    endtask

    task automatic test_extremes();
        int first[4] = '{32767, -32768, -4, -5};
        int rest[4]  = '{32767, -32768, 0, 0};
        int want[4]  = '{32767, -32768, 0, -1};
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < N; i++) step((i == 0) ? first[t] : rest[t], 1'b1, 1'b0);
            tests_run++;
            if (O_tvalid !== 1'b1 || O_tdata !== WIDTH'(want[t])) begin
                tests_failed++;
                $display("FAIL extremes case %0d: O_tvalid=%0b O_tdata=%0d, want 1/%0d",
                         t, O_tvalid, $signed(O_tdata), want[t]);
            end
        end
    endtask

    task automatic test_sync();
        int pulses = 0;
        for (int i = 1; i <= 16; i++) begin
            step(7, 1'b1, (i == 5));
            if (O_tvalid === 1'b1) pulses++;
            tests_run++;
            // sync beat is beat 5; window closes on beat 12
            if (O_tvalid !== (i == 12) || O_tdata !== m_data) begin
                tests_failed++;
                $display("FAIL sync beat %0d: O_tvalid=%0b O_tdata=%0d, want %0b/%0d",
                         i, O_tvalid, O_tdata, (i == 12), m_data);
            end
        end
        tests_run++;
        if (pulses != 1 || O_tdata !== 16'd7) begin
            tests_failed++;
            $display("FAIL sync result: pulses=%0d O_tdata=%0d, want 1/7", pulses, O_tdata);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) step(1000, 1'b1, 1'b0);
        do_reset(2);
        tests_run++;
        if (O_tvalid !== 1'b0 || O_tdata !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_mid: O_tvalid=%0b O_tdata=%0d, want 0/0", O_tvalid, O_tdata);
        end
        rst_n = 1'b1;
        for (int i = 1; i <= N; i++) begin
            step(-20, 1'b1, 1'b0);
            tests_run++;
            if (O_tvalid !== (i == N) || O_tdata !== m_data) begin
                tests_failed++;
                $display("FAIL reset_mid beat %0d: O_tvalid=%0b O_tdata=%0d, want %0b/%0d",
                         i, O_tvalid, O_tdata, (i == N), m_data);
            end
        end
        tests_run++;
        if (O_tdata !== 16'hFFEC) begin
            tests_failed++;
            $display("FAIL reset_mid value: O_tdata=%0d, want -20", $signed(O_tdata));
        end
    endtask

    task automatic test_back_to_back();
        int want[3] = '{5, 13, 21};
        int k = 0;
        int last_pulse = 0;
        for (int i = 1; i <= 24; i++) begin
            step(i, 1'b1, 1'b0);
            tests_run++;
            if (O_tvalid !== ((i % N) == 0)) begin
                tests_failed++;
                $display("FAIL b2b valid beat %0d: O_tvalid=%0b, want %0b", i, O_tvalid, ((i % N) == 0));
            end
            if (O_tvalid === 1'b1 && k < 3) begin
                tests_run++;
                if (O_tdata !== WIDTH'(want[k]) || (k > 0 && i - last_pulse != N)) begin
                    tests_failed++;
                    $display("FAIL b2b pulse %0d: O_tdata=%0d spacing=%0d, want %0d/%0d",
                             k, O_tdata, i - last_pulse, want[k], N);
                end
                last_pulse = i;
                k++;
            end
        end
        tests_run++;
        if (k != 3) begin
            tests_failed++;
            $display("FAIL b2b pulse count: %0d, want 3", k);
        end
    endtask

    task automatic test_random();
        int pulses = 0;
        for (int c = 0; c < 600; c++) begin
            step(rand_sample(), ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0));
            if (m_valid) pulses++;
            tests_run++;
            if (O_tvalid !== m_valid || O_tdata !== m_data) begin
                tests_failed++;
                $display("FAIL random cycle %0d: O_tvalid=%0b O_tdata=%0d, want %0b/%0d",
                         c, O_tvalid, O_tdata, m_valid, m_data);
            end
        end
        tests_run++;
        if (pulses < 10) begin
            tests_failed++;
            $display("FAIL random coverage: pulses=%0d, want >= 10", pulses);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        I_tdata  = '0;
        I_tvalid = 1'b0;
        I_sync   = 1'b0;
        m_valid  = 1'b0;
        m_data   = '0;
        test_reset();
        test_constant();
        test_ramp_gaps();
        test_extremes();
        test_sync();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
